// File: rtl/threshold_calibrator_pkg.sv
// Shared types and width helpers for the threshold calibrator and its min/max window tracker.
package threshold_calibrator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_COMPUTE,
    ST_APPLY
  } cal_state_t;

  // Arithmetic width for span/center/margin: one bit wider than a channel sample.
  function automatic int span_width(input int ch_w);
    return ch_w + 1;
  endfunction

  // Running-minimum start value: most positive channel value.
  function automatic logic signed [31:0] ch_pos_max(input int ch_w);
    return (32'sd1 <<< (ch_w - 1)) - 32'sd1;
  endfunction

  // Running-maximum start value: most negative channel value.
  function automatic logic signed [31:0] ch_neg_max(input int ch_w);
    return -(32'sd1 <<< (ch_w - 1));
  endfunction

endpackage

// File: rtl/threshold_calibrator_minmax_tracker.sv
// Windowed signed min/max accumulator; window_done flags the sample that completes 2^WINDOW_LOG accepted samples.
module minmax_tracker
  import threshold_calibrator_pkg::*;
#(
  parameter int CH_W       = 16,
  parameter int WINDOW_LOG = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   clear,
  input  logic                   valid,
  input  logic signed [CH_W-1:0] sample,
  output logic signed [CH_W-1:0] min_val,
  output logic signed [CH_W-1:0] max_val,
  output logic                   window_done
);

  localparam logic signed [CH_W-1:0] MIN_INIT = CH_W'(ch_pos_max(CH_W));
  localparam logic signed [CH_W-1:0] MAX_INIT = CH_W'(ch_neg_max(CH_W));

  logic [WINDOW_LOG-1:0] cnt;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (valid) begin
      cnt <= cnt + WINDOW_LOG'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (clear) begin
      min_val <= MIN_INIT;
      max_val <= MAX_INIT;
    end else if (valid) begin
      if (sample < min_val) min_val <= sample;
      if (sample > max_val) max_val <= sample;
    end
  end

  assign window_done = valid && (cnt == '1);

endmodule

// File: rtl/threshold_calibrator.sv
// Derives a hysteresis threshold pair from the min/max of channel A over a sample window.
// Build option: define CAL_AUTO_RESTART_EN to re-arm a new window after every result.
module threshold_calibrator
  import threshold_calibrator_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int WINDOW_LOG         = 16,
  parameter int HYST_SHIFT         = 3
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   cal_start,
  input  logic                                   cal_abort,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] cal_default_lower,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] cal_default_upper,
  input  logic        [S_AXIS_TDATA_WIDTH/2-1:0] cal_min_span,
  input  logic                                   S_AXIS_tvalid,
  input  logic        [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  output logic                                   S_AXIS_tready,
  output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold,
  output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold,
  output logic                                   cal_busy,
  output logic                                   cal_done,
  output logic                                   cal_error,
  output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] cal_min_obs,
  output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] cal_max_obs
);

  localparam int CH_W   = S_AXIS_TDATA_WIDTH / 2;
  localparam int SPAN_W = span_width(CH_W);

  function automatic logic signed [SPAN_W-1:0] sext(input logic signed [CH_W-1:0] v);
    return SPAN_W'(v);
  endfunction

  function automatic logic signed [SPAN_W-1:0] floor_half(input logic signed [SPAN_W-1:0] v);
    return v >>> 1;
  endfunction

  // Lossless: lower/upper always lie within [min, max].
  function automatic logic signed [CH_W-1:0] trunc_ch(input logic signed [SPAN_W-1:0] v);
    return v[CH_W-1:0];
  endfunction

  cal_state_t state, state_nxt;
  logic clear_win, do_compute, do_apply, win_done, smp_valid, span_short;
  logic signed [CH_W-1:0]   ch_a, win_min, win_max;
  logic signed [SPAN_W-1:0] span_c, center_c, margin_c, lower_c, upper_c;
  logic signed [SPAN_W-1:0] span_p0;
  logic signed [CH_W-1:0]   lower_p0, upper_p0;
  logic signed [CH_W-1:0]   lower_q, upper_q;
  logic                     cal_valid;
  logic                     unused_tdata_hi;

  assign ch_a            = S_AXIS_tdata[CH_W-1:0];
  assign unused_tdata_hi = ^S_AXIS_tdata[S_AXIS_TDATA_WIDTH-1:CH_W];
  assign smp_valid       = S_AXIS_tvalid && (state == ST_MEASURE);
  assign S_AXIS_tready   = 1'b1;

  minmax_tracker #(
    .CH_W      (CH_W),
    .WINDOW_LOG(WINDOW_LOG)
  ) u_minmax (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .clear      (clear_win),
    .valid      (smp_valid),
    .sample     (ch_a),
    .min_val    (win_min),
    .max_val    (win_max),
    .window_done(win_done)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    clear_win  = 1'b0;
    do_compute = 1'b0;
    do_apply   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cal_start) begin
          state_nxt = ST_MEASURE;
          clear_win = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (win_done) state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        do_compute = 1'b1;
        state_nxt  = ST_APPLY;
      end
      ST_APPLY: begin
        do_apply = 1'b1;
`ifdef CAL_AUTO_RESTART_EN
        state_nxt = ST_MEASURE;
        clear_win = 1'b1;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort overrides every transition, including the window-ending sample.
    if (cal_abort) begin
      state_nxt  = ST_IDLE;
      clear_win  = 1'b0;
      do_compute = 1'b0;
      do_apply   = 1'b0;
    end
  end

  always_comb begin
    span_c   = sext(win_max) - sext(win_min);
    center_c = floor_half(sext(win_max) + sext(win_min));
    margin_c = span_c >>> HYST_SHIFT;
    lower_c  = center_c - margin_c;
    upper_c  = center_c + margin_c;
  end

  // Stage p0: COMPUTE registers the derived pair.
  always_ff @(posedge aclk) begin
    if (do_compute) begin
      span_p0  <= span_c;
      lower_p0 <= trunc_ch(lower_c);
      upper_p0 <= trunc_ch(upper_c);
    end
  end

  assign span_short = $unsigned(span_p0) < {1'b0, cal_min_span};

  // Stage p1: APPLY commits thresholds and result pulses in one edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cal_valid   <= 1'b0;
      lower_q     <= '0;
      upper_q     <= '0;
      cal_min_obs <= '0;
      cal_max_obs <= '0;
      cal_done    <= 1'b0;
      cal_error   <= 1'b0;
    end else begin
      cal_done  <= 1'b0;
      cal_error <= 1'b0;
      if (do_apply) begin
        cal_min_obs <= win_min;
        cal_max_obs <= win_max;
        if (span_short) begin
          cal_error <= 1'b1;
        end else begin
          lower_q   <= lower_p0;
          upper_q   <= upper_p0;
          cal_valid <= 1'b1;
          cal_done  <= 1'b1;
        end
      end
    end
  end

  assign cal_busy           = (state != ST_IDLE);
  assign FC_lower_threshold = cal_valid ? lower_q : cal_default_lower;
  assign FC_upper_threshold = cal_valid ? upper_q : cal_default_upper;

endmodule
